// File: rtl/mem_line_arbiter_if.sv
// rtl/mem_line_arbiter_if.sv - cache-client and pmem burst signals of the line arbiter
interface mem_line_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
);
    logic              i_read_i;
    logic [31:0]       i_addr_i;
    logic [LINE_W-1:0] i_rdata_o;
    logic              i_resp_o;
    logic              d_read_i;
    logic              d_write_i;
    logic [31:0]       d_addr_i;
    logic [LINE_W-1:0] d_wdata_i;
    logic [LINE_W-1:0] d_rdata_o;
    logic              d_resp_o;
    logic              pmem_read_o;
    logic              pmem_write_o;
    logic [31:0]       pmem_addr_o;
    logic [BEAT_W-1:0] pmem_wdata_o;
    logic [BEAT_W-1:0] pmem_rdata_i;
    logic              pmem_resp_i;

    modport slave (
        input  i_read_i, i_addr_i, d_read_i, d_write_i, d_addr_i, d_wdata_i,
               pmem_rdata_i, pmem_resp_i,
        output i_rdata_o, i_resp_o, d_rdata_o, d_resp_o,
               pmem_read_o, pmem_write_o, pmem_addr_o, pmem_wdata_o
    );

    modport master (
        output i_read_i, i_addr_i, d_read_i, d_write_i, d_addr_i, d_wdata_i,
               pmem_rdata_i, pmem_resp_i,
        input  i_rdata_o, i_resp_o, d_rdata_o, d_resp_o,
               pmem_read_o, pmem_write_o, pmem_addr_o, pmem_wdata_o
    );
endinterface

// File: rtl/mem_line_arbiter.sv
// rtl/mem_line_arbiter.sv - I/D cache line arbiter serialising lines into 4-beat pmem bursts
module mem_line_arbiter #(
    parameter int LINE_W     = 256,
    parameter int BEAT_W     = 64,
    parameter int STARVE_MAX = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_line_arbiter_if.slave  bus
);
    localparam int NBEATS = LINE_W / BEAT_W;
    localparam int CW     = $clog2(NBEATS);
    localparam int SW     = $clog2(STARVE_MAX + 1);
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFE0;

    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE_I, DONE_D} state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  beat_q, beat_d;
    logic [NBEATS-1:0][BEAT_W-1:0]  line_q, line_d;
    logic [SW-1:0]                  streak_q, streak_d;
    logic [31:0]                    addr_q, addr_d;
    logic [NBEATS-1:0][BEAT_W-1:0]  wdata_beats;
    logic                           d_req;
    logic                           d_wins;

    assign wdata_beats = bus.d_wdata_i;
    assign d_req       = bus.d_read_i | bus.d_write_i;
    // D has priority until it has starved a waiting I request STARVE_MAX times in a row
    assign d_wins      = d_req && !(bus.i_read_i && (streak_q == SW'(STARVE_MAX)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            line_q   <= '0;
            streak_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            line_q   <= line_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        line_d   = line_q;
        streak_d = streak_q;
        addr_d   = addr_q;
        case (state_q)
            IDLE: begin
                if (d_wins) begin
                    state_d = bus.d_write_i ? D_WR : D_RD;
                    addr_d  = bus.d_addr_i & LINE_MASK;
                    if (bus.i_read_i && (streak_q != SW'(STARVE_MAX))) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (bus.i_read_i) begin
                    state_d  = I_RD;
                    addr_d   = bus.i_addr_i & LINE_MASK;
                    streak_d = '0;
                end
            end
            I_RD, D_RD, D_WR: begin
                if (bus.pmem_resp_i) begin
                    if (state_q != D_WR) begin
                        line_d[beat_q] = bus.pmem_rdata_i;
                    end
                    beat_d = beat_q + 1'b1;
                    if (beat_q == CW'(NBEATS - 1)) begin
                        beat_d  = '0;
                        state_d = (state_q == I_RD) ? DONE_I : DONE_D;
                    end
                end
            end
            DONE_I, DONE_D: state_d = IDLE;
            default:        state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.pmem_read_o  = 1'b0;
        bus.pmem_write_o = 1'b0;
        bus.pmem_addr_o  = '0;
        bus.pmem_wdata_o = '0;
        bus.i_resp_o     = 1'b0;
        bus.d_resp_o     = 1'b0;
        bus.i_rdata_o    = '0;
        bus.d_rdata_o    = '0;
        case (state_q)
            I_RD, D_RD: begin
                bus.pmem_read_o = 1'b1;
                bus.pmem_addr_o = addr_q;
            end
            D_WR: begin
                bus.pmem_write_o = 1'b1;
                bus.pmem_addr_o  = addr_q;
                bus.pmem_wdata_o = wdata_beats[beat_q];
            end
            DONE_I: begin
                bus.i_resp_o  = 1'b1;
                bus.i_rdata_o = line_q;
            end
            DONE_D: begin
                bus.d_resp_o  = 1'b1;
                bus.d_rdata_o = line_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb/tb_mem_line_arbiter.sv - directed self-checking bench for mem_line_arbiter
module tb_mem_line_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    mem_line_arbiter_if #(.LINE_W(256), .BEAT_W(64)) bus();

    mem_line_arbiter #(.LINE_W(256), .BEAT_W(64), .STARVE_MAX(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".ctl"}, {252'd0, bus.pmem_read_o, bus.pmem_write_o, bus.i_resp_o, bus.d_resp_o}, 256'd0);
        check({tag, ".addr"}, {224'd0, bus.pmem_addr_o}, 256'd0);
        check({tag, ".wdata"}, {192'd0, bus.pmem_wdata_o}, 256'd0);
        check({tag, ".irdata"}, bus.i_rdata_o, 256'd0);
        check({tag, ".drdata"}, bus.d_rdata_o, 256'd0);
    endtask

    task automatic check_strobe(input string tag, input logic rd);
        check({tag, ".strobe"}, {254'd0, bus.pmem_read_o, bus.pmem_write_o}, rd ? 256'd2 : 256'd1);
    endtask

    // Serves four beats with `gap` idle cycles before each; ends in the DONE cycle
    task automatic run_burst(input string tag, input int gap, input logic rd,
                             input logic [255:0] rline, input logic [255:0] wline);
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                check_strobe(tag, rd);
                tick();
            end
            bus.pmem_resp_i  = 1'b1;
            bus.pmem_rdata_i = rline[k*64 +: 64];
            check_strobe(tag, rd);
            if (!rd) check({tag, ".wbeat"}, {192'd0, bus.pmem_wdata_o}, {192'd0, wline[k*64 +: 64]});
            tick();
            bus.pmem_resp_i = 1'b0;
        end
    endtask

    // In the DONE cycle: check the pulse, drop the request, confirm the pulse lasted one cycle
    task automatic finish_resp(input string tag, input logic is_i, input logic chk_data,
                               input logic [255:0] line);
        check({tag, ".resp"}, {254'd0, bus.i_resp_o, bus.d_resp_o}, is_i ? 256'd2 : 256'd1);
        check({tag, ".nostrobe"}, {254'd0, bus.pmem_read_o, bus.pmem_write_o}, 256'd0);
        if (chk_data) check({tag, ".rdata"}, is_i ? bus.i_rdata_o : bus.d_rdata_o, line);
        check({tag, ".otherdata"}, is_i ? bus.d_rdata_o : bus.i_rdata_o, 256'd0);
        if (is_i) bus.i_read_i = 1'b0;
        else begin
            bus.d_read_i  = 1'b0;
            bus.d_write_i = 1'b0;
        end
        tick();
        check({tag, ".pulse1"}, {254'd0, bus.i_resp_o, bus.d_resp_o}, 256'd0);
        check({tag, ".rdata0"}, bus.i_rdata_o | bus.d_rdata_o, 256'd0);
    endtask

    initial begin
        logic [255:0] iline;
        logic [255:0] wline;
        logic [255:0] line;
        logic         exp_i;

        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        bus.i_read_i = 1'b0;  bus.i_addr_i = '0;
        bus.d_read_i = 1'b0;  bus.d_write_i = 1'b0;
        bus.d_addr_i = '0;    bus.d_wdata_i = '0;
        bus.pmem_rdata_i = '0; bus.pmem_resp_i = 1'b0;

        // reset then idle with stray pmem_resp pulses
        tick();
        tick();
        check_quiet("reset");
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.pmem_resp_i  = c[0];
            bus.pmem_rdata_i = 64'hDEAD_BEEF_0000_0000 | 64'(c);
            tick();
            check_quiet("idle");
        end
        bus.pmem_resp_i = 1'b0;

        // I read with 2-cycle gaps between beats
        iline = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        bus.i_addr_i = 32'h0000_1234;
        bus.i_read_i = 1'b1;
        tick();
        check("iread.addr", {224'd0, bus.pmem_addr_o}, {224'd0, 32'h0000_1220});
        run_burst("iread", 2, 1'b1, iline, 256'd0);
        finish_resp("iread", 1'b1, 1'b1, iline);

        // D write with pmem_resp held high: strobe cycles 1-4, resp cycle 5
        wline = {{15{16'hAAAA}}, 16'h0001};
        bus.d_addr_i  = 32'h8000_0040;
        bus.d_wdata_i = wline;
        bus.d_write_i = 1'b1;
        check_quiet("dwrite.c0");
        tick();
        check("dwrite.addr", {224'd0, bus.pmem_addr_o}, {224'd0, 32'h8000_0040});
        run_burst("dwrite", 0, 1'b0, 256'd0, wline);
        finish_resp("dwrite", 1'b0, 1'b0, 256'd0);

        // simultaneous I and D from IDLE with empty streak: D then I
        bus.d_addr_i = 32'h0000_3000;
        bus.i_addr_i = 32'h0000_4000;
        bus.d_read_i = 1'b1;
        bus.i_read_i = 1'b1;
        tick();
        check("both.dfirst", {224'd0, bus.pmem_addr_o}, {224'd0, 32'h0000_3000});
        line = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
        run_burst("both.d", 0, 1'b1, line, 256'd0);
        finish_resp("both.d", 1'b0, 1'b1, line);
        check("both.idle", {254'd0, bus.pmem_read_o, bus.pmem_write_o}, 256'd0);
        tick();
        check("both.inext", {224'd0, bus.pmem_addr_o}, {224'd0, 32'h0000_4000});
        line = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
        run_burst("both.i", 0, 1'b1, line, 256'd0);
        finish_resp("both.i", 1'b1, 1'b1, line);

        // continuous contention: grant order D, D, I, D, D, I
        bus.d_read_i = 1'b1;
        bus.i_read_i = 1'b1;
        for (int g = 0; g < 6; g++) begin
            exp_i = (g % 3 == 2);
            line = {64'(g) << 8 | 64'h3, 64'(g) << 8 | 64'h2, 64'(g) << 8 | 64'h1, 64'(g) << 8};
            tick();
            check("starve.grant", {224'd0, bus.pmem_addr_o}, {224'd0, exp_i ? 32'h0000_4000 : 32'h0000_3000});
            run_burst("starve", 0, 1'b1, line, 256'd0);
            finish_resp("starve", exp_i, 1'b1, line);
            if (g < 5) begin
                if (exp_i) bus.i_read_i = 1'b1;
                else       bus.d_read_i = 1'b1;
            end else begin
                bus.d_read_i = 1'b0;
            end
        end
        tick();
        check_quiet("starve.end");

        // reset after the 2nd beat of a D read
        bus.d_addr_i = 32'h0000_5000;
        bus.d_read_i = 1'b1;
        tick();
        check_strobe("rst.pre", 1'b1);
        bus.pmem_resp_i  = 1'b1;
        bus.pmem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        tick();
        rst = 1'b0;
        bus.d_read_i = 1'b0;
        tick();
        check_quiet("rst.mid");
        rst = 1'b1;
        tick();
        check_quiet("rst.ignore1");
        tick();
        check_quiet("rst.ignore2");
        bus.pmem_resp_i = 1'b0;
        line = {64'h7777777777777777, 64'h6666666666666666, 64'h5555555555555555, 64'h0123456789ABCDEF};
        bus.i_addr_i = 32'h0000_205F;
        bus.i_read_i = 1'b1;
        tick();
        check("rst.iaddr", {224'd0, bus.pmem_addr_o}, {224'd0, 32'h0000_2040});
        run_burst("rst.i", 1, 1'b1, line, 256'd0);
        finish_resp("rst.i", 1'b1, 1'b1, line);
        check_quiet("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Arbitrates I-cache line reads and D-cache line reads/writes onto the single physical-memory burst port.
- Serialises each 256-bit line into a 4-beat, 64-bit burst.
- Produces the per-client line responses that drive instr_mem_resp_i and data_mem_resp_i of the pipeline memory-stall unit.
- Sits between the two caches and pmem.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, pmem data width per burst beat. NBEATS = LINE_W/BEAT_W = 4.
- STARVE_MAX, 2, maximum consecutive D grants allowed while an I request waits.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset; state resets while rst==0 at posedge.
- i_read_i  in  1  I-cache line read request; held until i_resp_o.
- i_addr_i  in  32  I-cache line address.
- i_rdata_o  out  LINE_W  line read for the I-cache; valid only while i_resp_o==1.
- i_resp_o  out  1  one-cycle pulse: I request complete.
- d_read_i  in  1  D-cache line read request; held until d_resp_o.
- d_write_i  in  1  D-cache line write request; held until d_resp_o.
- d_addr_i  in  32  D-cache line address.
- d_wdata_i  in  LINE_W  line to write; stable while d_write_i==1.
- d_rdata_o  out  LINE_W  line read for the D-cache; valid only while d_resp_o==1.
- d_resp_o  out  1  one-cycle pulse: D request complete.
- pmem_read_o  out  1  burst read strobe; held for the entire burst.
- pmem_write_o  out  1  burst write strobe; held for the entire burst.
- pmem_addr_o  out  32  burst base address; bits [4:0] forced to 0.
- pmem_wdata_o  out  BEAT_W  current write beat.
- pmem_rdata_i  in  BEAT_W  read beat; valid when pmem_resp_i==1.
- pmem_resp_i  in  1  beat accepted/valid; one pulse per beat, 4 per burst.

Behaviour:
- States: IDLE, I_RD, D_RD, D_WR, DONE_I, DONE_D. Output strobes and resps are decoded from the state register.
- Reset (rst==0 at posedge), including mid-burst:
  - state=IDLE, beat counter=0, line buffer=0, d_streak=0, latched address=0.
  - All outputs 0 in the following cycle; an in-flight burst is abandoned.
  - pmem_resp_i pulses arriving after reset are ignored.
- IDLE arbitration, evaluated each cycle:
  - Only d pending: D wins.
  - Only i pending: I wins.
  - Both pending: D wins unless d_streak==STARVE_MAX, in which case I wins.
  - d_read_i and d_write_i both high is illegal; treat it as a write.
- On grant:
  - Latch the address, masked to {addr[31:5],5'b0}.
  - Move to I_RD, D_RD or D_WR. The strobe asserts in the next cycle, so latency is 1 cycle from request to pmem strobe.
- d_streak:
  - +1 (saturating at STARVE_MAX) on a D grant while i_read_i==1.
  - Cleared on an I grant.
  - Unchanged on a D grant while i_read_i==0.
- Burst:
  - The beat counter (2 bits) starts at 0 and increments on each pmem_resp_i in a burst state.
  - Beat k maps to line bits [64k+63:64k].
  - Reads: on pmem_resp_i, capture pmem_rdata_i into line buffer slice k.
  - Writes: pmem_wdata_o = d_wdata_i slice k combinationally. In non-write states it is 0.
  - On the pmem_resp_i with counter==3: go to DONE_I (from I_RD) or DONE_D (from D_RD/D_WR), and reset the counter to 0. The strobe drops in that next cycle.
- DONE_I / DONE_D:
  - Assert the matching resp for exactly 1 cycle.
  - i_rdata_o = d_rdata_o = line buffer; both are 0 outside their resp cycle.
  - Then return to IDLE.
  - The client drops its request at the edge after resp, so IDLE never re-grants a completed request.
- Ordering: a request raised during another client's burst waits; it is evaluated in IDLE after DONE.
- pmem_resp_i is ignored in IDLE/DONE states.
- No simultaneous pmem_read_o and pmem_write_o, ever.
- Request-to-resp latency = 1 + (cycles to 4th pmem_resp_i) + 1. With pmem_resp_i tied 1: request cycle 0, strobe cycles 1-4, resp cycle 5.

Test Plan:
- Reset then idle, no requests -> all outputs 0 for 10 cycles; stray pmem_resp_i pulses cause no state change.
- I read of addr 0x0000_1234, pmem returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 with 2-cycle gaps:
  - pmem_addr_o==0x0000_1220, pmem_read_o held through the 4th beat.
  - i_resp_o for 1 cycle with i_rdata_o=={0x44..44,0x33..33,0x22..22,0x11..11}; d_resp_o stays 0.
- D write of line 0xAAAA..._0001 to 0x8000_0040, pmem_resp_i tied 1:
  - pmem_write_o cycles 1-4 with wdata beats equal to slices 0..3.
  - d_resp_o at cycle 5; pmem_read_o never 1.
- i_read_i and d_read_i held continuously, re-raised after each resp:
  - Grant order D, D, I, D, D, I.
  - d_streak never exceeds 2; no I request waits more than 2 D bursts.
- I and D raised in the same cycle from IDLE with d_streak=0 -> D granted first; I granted immediately after DONE_D; each resp pulses exactly once.
- rst driven 0 after the 2nd beat of a D read -> next cycle pmem_read_o=0, no resp; a fresh I read afterwards completes normally with beat counter starting at 0.
